register_arbiter: RTL



---
 rtl/register_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/register_arbiter.sv
// Round-robin write arbiter that shares one N-bit register among NREQ requesters.
// Define REG_ARB_TIMEOUT_EN to bound a grant to MAX_HOLD write cycles when others wait.
module register_arbiter #(
  parameter int N        = 3,
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 4,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_d,
  output logic [NREQ-1:0]   gnt,
  output logic [IDW-1:0]    gnt_id,
  output logic              busy,
  output logic              reg_en,
  output logic [N-1:0]      reg_d
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   g, g_nx, ptr, ptr_nx;
  logic [IDW:0]     pick;
  logic             release_now, new_grant, timeout;

  if (NREQ < 2) begin : g_bad_nreq
    $error("register_arbiter: NREQ must be at least 2");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("register_arbiter: MAX_HOLD must be at least 1");
  end

  // Returns {found, index} of the first set request scanning start, start+1, ... mod NREQ.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] start);
    logic           found;
    logic [IDW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (int'(start) + i) % NREQ;
      if (!found && r[k]) begin
        found = 1'b1;
        idx   = k[IDW-1:0];
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    return (i == IDW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  assign busy   = (state == GRANT);
  assign gnt    = busy ? (NREQ'(1) << g) : '0;
  assign gnt_id = busy ? g : '0;
  assign reg_en = busy && req[g];
  assign reg_d  = reg_en ? req_d[int'(g)*N +: N] : '0;

`ifdef REG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt, cnt_inc, cnt_nx;
  logic          other_req;

  // cnt saturates at MAX_HOLD so a lone requester keeps its grant indefinitely.
  always_comb begin
    other_req = |(req & ~(NREQ'(1) << g));
    cnt_inc   = (cnt == CW'(MAX_HOLD)) ? cnt : cnt + 1'b1;
    timeout   = reg_en && (cnt_inc == CW'(MAX_HOLD)) && other_req;
    if (state_nx != GRANT || new_grant) begin
      cnt_nx = '0;
    end else if (reg_en) begin
      cnt_nx = cnt_inc;
    end else begin
      cnt_nx = cnt;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nx;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Release and re-arbitration share one edge, so a waiting requester sees no idle bubble.
  always_comb begin
    state_nx    = state;
    g_nx        = g;
    ptr_nx      = ptr;
    pick        = '0;
    release_now = 1'b0;
    new_grant   = 1'b0;
    case (state)
      IDLE: begin
        pick = rr_pick(req, ptr);
        if (pick[IDW]) begin
          state_nx  = GRANT;
          g_nx      = pick[IDW-1:0];
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        release_now = !req[g] || timeout;
        if (release_now) begin
          ptr_nx = next_idx(g);
          pick   = rr_pick(req, next_idx(g));
          if (pick[IDW]) begin
            g_nx      = pick[IDW-1:0];
            new_grant = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      g     <= g_nx;
      ptr   <= ptr_nx;
    end
  end

endmodule
